// File: rtl/jump_link_unit_if.sv
// EX-to-jump/link-unit bundle: resolved control-transfer in, redirect/link/flush/RAS status out.
interface jump_link_unit_if #(
   parameter int unsigned PC_W   = 9,
   parameter int unsigned DATA_W = 32
);
   logic              stall;
   logic              ex_valid;
   logic [1:0]        ex_op;
   logic              ex_taken;
   logic [PC_W-1:0]   ex_pc;
   logic [DATA_W-1:0] ex_target;
   logic [4:0]        ex_rd;
   logic [4:0]        ex_rs1;

   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              flush;
   logic              link_wen;
   logic [4:0]        link_rd;
   logic [DATA_W-1:0] link_data;
   logic              misalign;
   logic [PC_W-1:0]   ras_top;
   logic              ras_hit;

   modport master (
      output stall, ex_valid, ex_op, ex_taken, ex_pc, ex_target, ex_rd, ex_rs1,
      input  redirect_valid, redirect_pc, flush, link_wen, link_rd, link_data,
             misalign, ras_top, ras_hit
   );

   modport slave (
      input  stall, ex_valid, ex_op, ex_taken, ex_pc, ex_target, ex_rd, ex_rs1,
      output redirect_valid, redirect_pc, flush, link_wen, link_rd, link_data,
             misalign, ras_top, ras_hit
   );
endinterface

// File: rtl/jump_link_unit.sv
// Registered jump/branch resolution at EX/MEM: redirect, link writeback, wrong-path flush, misalign.
// Define JLU_RAS_EN to compile in the return-address stack used for ras_top/ras_hit.
module jump_link_unit #(
   parameter int unsigned PC_W         = 9,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned RAS_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   jump_link_unit_if.slave    jl
);
   localparam int unsigned CNT_W = 3;
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned RC_W  = PTR_W + 1;
   localparam logic [1:0]  OP_JAL  = 2'b01;
   localparam logic [1:0]  OP_JALR = 2'b10;
   localparam logic [1:0]  OP_BR   = 2'b11;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic              redir_valid_q, redir_valid_d;
   logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
   logic              link_wen_q, link_wen_d;
   logic [4:0]        link_rd_q, link_rd_d;
   logic [DATA_W-1:0] link_data_q, link_data_d;
   logic              misalign_q, misalign_d;

   logic              accept, is_jump, xfer, bad_align, go, do_link;
   logic [PC_W-1:0]   eff_pc, link_pc;

   // Instruction decode of the EX slot
   always_comb begin : decode
      eff_pc = jl.ex_target[PC_W-1:0];
      if (jl.ex_op == OP_JALR) eff_pc[0] = 1'b0;
      link_pc   = jl.ex_pc + PC_W'(4);
      accept    = jl.ex_valid && !jl.stall && (cnt_q == '0);
      is_jump   = (jl.ex_op == OP_JAL) || (jl.ex_op == OP_JALR);
      xfer      = accept && (is_jump || ((jl.ex_op == OP_BR) && jl.ex_taken));
      bad_align = xfer && eff_pc[1];
      go        = xfer && !eff_pc[1];
      do_link   = go && is_jump && (jl.ex_rd != 5'd0);
   end

   always_comb begin : next_state
      cnt_d         = cnt_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      link_wen_d    = link_wen_q;
      link_rd_d     = link_rd_q;
      link_data_d   = link_data_q;
      misalign_d    = misalign_q;
      if (!jl.stall) begin
         cnt_d         = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
         redir_valid_d = go;
         misalign_d    = bad_align;
         link_wen_d    = do_link;
         if (go) begin
            cnt_d      = CNT_W'(FLUSH_CYCLES);
            redir_pc_d = eff_pc;
         end
         if (do_link) begin
            link_rd_d   = jl.ex_rd;
            link_data_d = DATA_W'(link_pc);
         end
      end
      flush_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         flush_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         link_wen_q    <= 1'b0;
         link_rd_q     <= '0;
         link_data_q   <= '0;
         misalign_q    <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         flush_q       <= flush_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         link_wen_q    <= link_wen_d;
         link_rd_q     <= link_rd_d;
         link_data_q   <= link_data_d;
         misalign_q    <= misalign_d;
      end
   end

   assign jl.redirect_valid = redir_valid_q;
   assign jl.redirect_pc    = redir_pc_q;
   assign jl.flush          = flush_q;
   assign jl.link_wen       = link_wen_q;
   assign jl.link_rd        = link_rd_q;
   assign jl.link_data      = link_data_q;
   assign jl.misalign       = misalign_q;

`ifdef JLU_RAS_EN
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [PC_W-1:0]  ras_d [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [RC_W-1:0]  ras_cnt_q, ras_cnt_d;
   logic [PC_W-1:0]  ras_top_q, ras_top_d;
   logic             ras_hit_q, ras_hit_d;
   logic             push, pop;
   logic             unused_bits;

   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Circular stack: ptr_q names the top slot; a full push overwrites the oldest entry
   always_comb begin : ras_next
      push      = go && is_jump && is_link(jl.ex_rd);
      pop       = go && (jl.ex_op == OP_JALR) && is_link(jl.ex_rs1) &&
                  (!is_link(jl.ex_rd) || (jl.ex_rd != jl.ex_rs1));
      ras_d     = ras_q;
      ptr_d     = ptr_q;
      ras_cnt_d = ras_cnt_q;
      ras_hit_d = ras_hit_q;
      if (!jl.stall) begin
         ras_hit_d = 1'b0;
         if (pop && (ras_cnt_q != '0)) begin
            ras_hit_d = (ras_q[ptr_q] == eff_pc);
            ptr_d     = ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - RC_W'(1);
         end
         if (push) begin
            ptr_d        = ptr_d + PTR_W'(1);
            ras_d[ptr_d] = link_pc;
            if (ras_cnt_d != RC_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_d + RC_W'(1);
         end
      end
      ras_top_d = (ras_cnt_d == '0) ? '0 : ras_d[ptr_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
         ptr_q     <= '0;
         ras_cnt_q <= '0;
         ras_top_q <= '0;
         ras_hit_q <= 1'b0;
      end else begin
         ras_q     <= ras_d;
         ptr_q     <= ptr_d;
         ras_cnt_q <= ras_cnt_d;
         ras_top_q <= ras_top_d;
         ras_hit_q <= ras_hit_d;
      end
   end

   assign jl.ras_top = ras_top_q;
   assign jl.ras_hit = ras_hit_q;
   assign unused_bits = ^jl.ex_target[DATA_W-1:PC_W];
`else
   logic unused_bits;

   assign jl.ras_top  = '0;
   assign jl.ras_hit  = 1'b0;
   assign unused_bits = ^{jl.ex_target[DATA_W-1:PC_W], jl.ex_rs1};
`endif
endmodule

// File: tb/tb_jump_link_unit.sv
// Directed plus random stimulus for jump_link_unit against a queue-based behavioural model.
module tb_jump_link_unit;
   localparam int unsigned PC_W   = 9;
   localparam int unsigned DATA_W = 32;
   localparam int          FC     = 2;
   localparam int          DEPTH  = 4;
   localparam int          MASK   = (1 << PC_W) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   jump_link_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) jl_if ();

   jump_link_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .FLUSH_CYCLES(FC), .RAS_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .jl    (jl_if)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Reference model state
   int flush_left = 0;
   bit m_redir = 0, m_lwen = 0, m_mis = 0, m_hit = 0;
   int m_rpc = 0, m_lrd = 0, m_ldata = 0;
   int m_ras[$];

   function automatic bit is_link(input int r);
      return (r == 1) || (r == 5);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int op, tgt, lnk, rd, rs1;
      bit acc;
      if (reset) begin
         flush_left = 0; m_redir = 0; m_lwen = 0; m_mis = 0; m_hit = 0;
         m_rpc = 0; m_lrd = 0; m_ldata = 0;
         m_ras.delete();
      end else if (!jl_if.stall) begin
         op  = int'(jl_if.ex_op);
         rd  = int'(jl_if.ex_rd);
         rs1 = int'(jl_if.ex_rs1);
         acc = jl_if.ex_valid && (flush_left == 0);
         if (flush_left > 0) flush_left--;
         m_redir = 0; m_lwen = 0; m_mis = 0; m_hit = 0;
         if (acc && (op == 1 || op == 2 || (op == 3 && jl_if.ex_taken))) begin
            tgt = int'(jl_if.ex_target);
            if (op == 2) tgt = tgt & ~1;
            tgt = tgt & MASK;
            if ((tgt & 2) != 0) m_mis = 1;
            else begin
               m_redir = 1;
               m_rpc = tgt;
               flush_left = FC;
               if (op != 3) begin
                  lnk = (int'(jl_if.ex_pc) + 4) & MASK;
                  if (rd != 0) begin
                     m_lwen = 1; m_lrd = rd; m_ldata = lnk;
                  end
`ifdef JLU_RAS_EN
                  if (op == 2 && is_link(rs1) && !(is_link(rd) && rd == rs1) && m_ras.size() > 0)
                     m_hit = (m_ras.pop_back() == tgt);
                  if (is_link(rd)) begin
                     m_ras.push_back(lnk);
                     if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                  end
`endif
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      int top;
      top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 0;
      check({tag, ".redirect_valid"}, 32'(jl_if.redirect_valid), 32'(m_redir));
      check({tag, ".redirect_pc"},    32'(jl_if.redirect_pc),    32'(m_rpc));
      check({tag, ".flush"},          32'(jl_if.flush),          32'(flush_left != 0));
      check({tag, ".link_wen"},       32'(jl_if.link_wen),       32'(m_lwen));
      check({tag, ".link_rd"},        32'(jl_if.link_rd),        32'(m_lrd));
      check({tag, ".link_data"},      32'(jl_if.link_data),      32'(m_ldata));
      check({tag, ".misalign"},       32'(jl_if.misalign),       32'(m_mis));
      check({tag, ".ras_top"},        32'(jl_if.ras_top),        32'(top));
      check({tag, ".ras_hit"},        32'(jl_if.ras_hit),        32'(m_hit));
   endtask

   task automatic step(input string tag, input bit rst, input bit st, input bit v, input int op,
                       input bit tk, input int pc, input int tgt, input int rd, input int rs1);
      @(negedge clk);
      reset             = rst;
      jl_if.stall       = st;
      jl_if.ex_valid    = v;
      jl_if.ex_op       = 2'(op);
      jl_if.ex_taken    = tk;
      jl_if.ex_pc       = PC_W'(pc);
      jl_if.ex_target   = DATA_W'(tgt);
      jl_if.ex_rd       = 5'(rd);
      jl_if.ex_rs1      = 5'(rs1);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      jl_if.stall = 0; jl_if.ex_valid = 0; jl_if.ex_op = 0; jl_if.ex_taken = 0;
      jl_if.ex_pc = 0; jl_if.ex_target = 0; jl_if.ex_rd = 0; jl_if.ex_rs1 = 0;

      step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // JAL with link, then valid JALs arriving during the flush are dropped
      step("jal",     0, 0, 1, 1, 0, 'h010, 'h040, 1, 0);
      step("flush_a", 0, 0, 1, 1, 0, 'h020, 'h080, 3, 0);
      step("flush_b", 0, 0, 1, 1, 0, 'h020, 'h080, 3, 0);
      idle("post_jal", 1);

      // Reset held two cycles in the middle of a flush
      step("jal2",     0, 0, 1, 1, 0, 'h030, 'h0C0, 2, 0);
      step("rst_mid",  1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("rst_mid",  1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("after_rst", 1);

      // JALR clears bit 0; JALR to bit-1 target faults
      step("jalr81",   0, 0, 1, 2, 0, 'h030, 'h081, 0, 1);
      idle("jalr81_f", 2);
      step("jalr82",   0, 0, 1, 2, 0, 'h030, 'h082, 1, 2);
      idle("jalr82_f", 1);

      // Branches, and link PC wrapping at the top of the PC space
      step("br_nt",    0, 0, 1, 3, 0, 'h050, 'h100, 7, 0);
      step("br_t",     0, 0, 1, 3, 1, 'h050, 'h100, 7, 0);
      idle("br_f", 2);
      step("jal_wrap", 0, 0, 1, 1, 0, 'h1FC, 'h008, 5, 0);
      idle("wrap_f", 2);

      // Stall right after a JAL freezes pulses and counter
      step("jal_st",   0, 0, 1, 1, 0, 'h040, 'h060, 1, 0);
      for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 1, 0, 'h044, 'h0A0, 6, 0);
      idle("unstall", 3);

      // Return-address stack: 5 calls overflow a 4-deep stack, then 5 returns
      step("ras_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step("call", 0, 0, 1, 1, 0, 'h20 + 'h20 * i, 'h100, 1, 0);
         idle("call_f", 2);
      end
      for (int i = 4; i >= 0; i--) begin
         step("ret", 0, 0, 1, 2, 0, 'h100, 'h24 + 'h20 * i, 0, 1);
         idle("ret_f", 2);
      end

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         int rd, rs1, tgt;
         case ($urandom_range(3))
            0: rd = 0;
            1: rd = 1;
            2: rd = 5;
            default: rd = int'($urandom_range(31));
         endcase
         case ($urandom_range(3))
            0: rs1 = 0;
            1: rs1 = 1;
            2: rs1 = 5;
            default: rs1 = int'($urandom_range(31));
         endcase
         tgt = int'($urandom);
         if ($urandom_range(2) != 0) tgt = tgt & ~3;
         step("rand", ($urandom_range(49) == 0), ($urandom_range(7) == 0),
              ($urandom_range(3) != 0), int'($urandom_range(3)), 1'($urandom_range(1)),
              int'($urandom_range(MASK)), tgt, rd, rs1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/jump_link_unit.md
# jump_link_unit

Registered jump/branch resolution unit for the pipelined RV32I core, placed at the EX/MEM boundary. Takes the resolved control-transfer instruction from EX and does four things: produces a one-cycle-latency PC redirect, produces the link (PC+4) writeback for JAL/JALR, flushes wrong-path instructions for a programmable number of cycles, and flags misaligned targets. Replaces the old combinational JALR swap. Optionally includes a return-address stack (RAS) for return-hit statistics.

## Interface
Parameters:
- PC_W, 9, program-counter width in bits
- DATA_W, 32, register/ALU data width
- FLUSH_CYCLES, 2, cycles of flush after a redirect (1..7)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline hold; freezes all state and outputs
- ex_valid  in  1  EX instruction valid
- ex_op  in  2  00 none, 01 JAL, 10 JALR, 11 branch
- ex_taken  in  1  branch condition (used only for op 11)
- ex_pc  in  PC_W  PC of the EX instruction
- ex_target  in  DATA_W  computed target (ALU result for JALR, pc+imm otherwise)
- ex_rd  in  5  destination register
- ex_rs1  in  5  source register 1
- redirect_valid  out  1  redirect pulse
- redirect_pc  out  PC_W  new fetch PC
- flush  out  1  squash IF/ID/EX contents
- link_wen  out  1  link writeback enable
- link_rd  out  5  link destination
- link_data  out  DATA_W  zero-extended PC+4
- misalign  out  1  misaligned-target exception pulse
- ras_top  out  PC_W  current RAS top entry
- ras_hit  out  1  JALR return matched the popped RAS entry

## Operation
- Accept condition: ex_valid=1, stall=0 and flush counter=0. Otherwise EX input is ignored.
- Effective target: ex_target with bit 0 cleared for JALR, then truncated to PC_W.
- Transfer condition: op=JAL, op=JALR, or (op=branch and ex_taken=1).
- Misaligned transfer (effective target bit 1 set):
  - misalign=1.
  - No redirect, no link write, no RAS change, no flush.
- Aligned transfer:
  - redirect_valid=1, redirect_pc=effective target.
  - Flush counter loads FLUSH_CYCLES.
- Link write on JAL/JALR (even when misaligned = no; see above) when ex_rd≠0:
  - link_wen=1, link_rd=ex_rd.
  - link_data = {0, (ex_pc+4) mod 2^PC_W}.
  - ex_rd=0 gives link_wen=0.
- Untaken branch or op=00: all pulses 0.
- flush=1 while the counter is nonzero. The counter decrements each non-stalled cycle.
- Pulse outputs (redirect_valid, link_wen, misalign, ras_hit) last one non-stalled cycle. They hold their value while stall=1.
- Reset: all outputs 0, flush counter 0, RAS pointer and count 0, RAS entries 0.
- Reset during a flush: the counter clears and flush drops on the next edge.

## Timing
- Latency: input accepted at edge N; outputs valid after edge N+1, visible in cycle N+1.
- flush is high in cycles N+1 .. N+FLUSH_CYCLES. An ex_valid in those cycles is discarded.
- Back-to-back transfers: the second is accepted only after the flush ends.
- stall=1 freezes everything, including the counter and the RAS.

## Configuration
- JLU_RAS_EN defined: RAS compiled in.
  - Push: aligned JAL/JALR with rd ∈ {1,5} pushes the link PC.
  - Pop: aligned JALR with rs1 ∈ {1,5} and rd ∉ {1,5} pops.
  - ras_hit=1 when the popped entry equals redirect_pc.
  - rd and rs1 both link, and rd≠rs1: pop then push (top replaced).
  - rd and rs1 both link, and rd=rs1: push only.
  - Push when full: overwrites the oldest entry (circular; count saturates at RAS_DEPTH).
  - Pop when empty: ras_hit=0, pointer and count unchanged.
- JLU_RAS_EN undefined: no RAS storage; ras_top=0 and ras_hit=0 always.

## Test plan
- Reset: assert reset 2 cycles mid-flush -> all outputs 0, flush low the cycle after.
- JAL: JAL pc=0x010, target=0x040, rd=1 -> next cycle redirect_pc=0x040, link_rd=1, link_data=0x14; flush high 2 cycles; ex_valid during flush is ignored.
- JALR bit-0 clear and misalign:
  - JALR target=0x081, rd=0 -> redirect_pc=0x080, link_wen=0.
  - JALR target=0x082 -> misalign=1, no redirect, no flush.
- Branch and wrap:
  - Branch taken=0 -> no outputs.
  - JAL pc=0x1FC (PC_W=9), rd=5 -> link_data=0x000.
- Stall: stall=1 for 3 cycles right after a JAL -> redirect_valid and flush held, counter frozen; flush resumes for 2 cycles after stall drops.
- RAS (JLU_RAS_EN):
  - 5 calls with rd=1 -> first call overwritten.
  - 4 returns (jalr x0, 0(x1)) -> ras_hit=1 each.
  - 5th return -> ras_hit=0.
